// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl
// Sequencer for a shift-add multiplier datapath. The datapath is a 17-bit
// product/multiplier register plus an 8-bit adder. On a start request this
// block loads the register, then steps through WIDTH multiplier bits. For
// each bit it issues ADD (when the register LSB is 1) and SHIFT. When the
// operation finishes, it holds done until the requester acknowledges.
//
// Ports
//   clk         rising-edge clock
//   n_reset     asynchronous, active-low reset
//   start       operation request (taken in IDLE, or in DONE with result_ack)
//   lsb         register bit 0 from the datapath (current multiplier bit)
//   abort       cancel an operation in flight (LOAD/RUN/ADDC/DONE -> IDLE)
//   result_ack  consumer acknowledge of done
//   RESET       load the register with {0, multiplier}
//   ADD         write {carry,sum} into the upper register half
//   SHIFT       shift the register right by one
//   ready       idle, a start will be accepted
//   busy        operation in progress (LOAD, RUN, ADDC)
//   done        product valid in the register, held until result_ack
//   count       shift steps completed in the current or last operation

module mult_seq_ctrl #(
    parameter int WIDTH    = 8,
    parameter bit COMBINED = 1'b1,
    localparam int CW      = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          start,
    input  logic          lsb,
    input  logic          abort,
    input  logic          result_ack,
    output logic          RESET,
    output logic          ADD,
    output logic          SHIFT,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        ADDC,
        DONE
    } state_t;

    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t state;

    // Abort takes precedence over every other transition, and count is
    // frozen on abort so the requester can see how far the operation got.
    // When count reads LAST_STEP on a shift cycle, that shift is the final
    // one, so the next state is DONE with count reaching WIDTH.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (COMBINED || !lsb) begin
                        count <= count + 1'b1;
                        state <= (count == LAST_STEP) ? DONE : RUN;
                    end else begin
                        state <= ADDC;
                    end
                end
                ADDC: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                        state <= (count == LAST_STEP) ? DONE : RUN;
                    end
                end
                DONE: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (result_ack) begin
                        state <= start ? LOAD : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from the state register. ADD in RUN also follows
    // lsb directly, because the register's current bit decides whether this
    // step adds.
    // In the separate-cycle mode, an LSB=1 bit spends its RUN cycle adding.
    // The shift for that bit then happens in ADDC.
    always_comb begin
        RESET = 1'b0;
        ADD   = 1'b0;
        SHIFT = 1'b0;
        case (state)
            LOAD: RESET = 1'b1;
            RUN: begin
                ADD = lsb;
                if (COMBINED) SHIFT = 1'b1;
                else          SHIFT = ~lsb;
            end
            ADDC: SHIFT = 1'b1;
            default: ;
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state == LOAD) || (state == RUN) || (state == ADDC);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl
// Bench for mult_seq_ctrl. It has two instances: instance 0 with
// COMBINED=1 and instance 1 with COMBINED=0. Each instance drives a
// behavioural 17-bit shift-add register, and that register feeds lsb back
// to the instance. Issued operations push their expected product, latency
// and ADD pattern into a per-instance queue. A negedge monitor pops an
// entry whenever done rises and compares it against the register and the
// control activity it observed.

module tb_mult_seq_ctrl;

    localparam int WIDTH = 8;

    typedef struct {
        logic [15:0] product;
        int          lat;
        logic [7:0]  pat;
        int          start_edge;
    } exp_t;

    logic       clk;
    logic       n_reset;
    logic       start_s [2];
    logic       abort_s [2];
    logic       ack_s   [2];
    logic       rst_o   [2];
    logic       add_o   [2];
    logic       shift_o [2];
    logic       ready_o [2];
    logic       busy_o  [2];
    logic       done_o  [2];
    logic [3:0] count_o [2];

    logic [16:0] dp     [2];
    logic [7:0]  mcand  [2];
    logic [7:0]  mplier [2];

    exp_t sb0[$];
    exp_t sb1[$];

    int         edge_cnt;
    int         errors;
    int         checks;
    int         shifts   [2];
    logic [7:0] pat_r    [2];
    logic       prev_add [2];
    logic       prev_done[2];

    mult_seq_ctrl #(.WIDTH(WIDTH), .COMBINED(1'b1)) dut_c (
        .clk(clk), .n_reset(n_reset), .start(start_s[0]), .lsb(dp[0][0]),
        .abort(abort_s[0]), .result_ack(ack_s[0]), .RESET(rst_o[0]),
        .ADD(add_o[0]), .SHIFT(shift_o[0]), .ready(ready_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .count(count_o[0])
    );

    mult_seq_ctrl #(.WIDTH(WIDTH), .COMBINED(1'b0)) dut_s (
        .clk(clk), .n_reset(n_reset), .start(start_s[1]), .lsb(dp[1][0]),
        .abort(abort_s[1]), .result_ack(ack_s[1]), .RESET(rst_o[1]),
        .ADD(add_o[1]), .SHIFT(shift_o[1]), .ready(ready_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .count(count_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Register model: load {0, multiplier}. An add replaces the upper nine
    // bits with carry and sum. A shift moves everything right by one. When
    // ADD and SHIFT occur together, the add happens first.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [16:0] t;
            t = dp[i];
            if (rst_o[i]) begin
                t = {9'd0, mplier[i]};
            end else begin
                if (add_o[i])   t[16:8] = {1'b0, t[15:8]} + {1'b0, mcand[i]};
                if (shift_o[i]) t = t >> 1;
            end
            dp[i] <= t;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // The ADD pattern is recorded per shift. A bit counts as "added" if ADD
    // was high in that shift cycle (combined mode) or in the cycle just
    // before it (separate mode). Either way, the pattern must equal the
    // multiplier.
    task automatic monitor_step(input int i);
        exp_t e;
        logic viol;
        if (rst_o[i]) begin
            shifts[i]   = 0;
            pat_r[i]    = '0;
            prev_add[i] = 1'b0;
        end
        if (shift_o[i]) begin
            if (shifts[i] < WIDTH) pat_r[i][shifts[i]] = add_o[i] | prev_add[i];
            shifts[i]++;
        end
        prev_add[i] = add_o[i] & ~shift_o[i];

        viol = (rst_o[i] & (add_o[i] | shift_o[i])) |
               ((i == 1) & add_o[i] & shift_o[i]) |
               ((i == 0) & add_o[i] & ~shift_o[i]);
        check_output($sformatf("invariant%0d", i), {31'd0, viol}, 32'd0);

        if (done_o[i] && !prev_done[i]) begin
            if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
                check_output($sformatf("unexpected_done%0d", i), 32'd1, 32'd0);
            end else begin
                if (i == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                check_output($sformatf("product%0d", i), {16'd0, dp[i][15:0]},
                             {16'd0, e.product});
                check_output($sformatf("latency%0d", i),
                             edge_cnt - e.start_edge + 1, e.lat);
                check_output($sformatf("count%0d", i), {28'd0, count_o[i]}, WIDTH);
                check_output($sformatf("shifts%0d", i), shifts[i], WIDTH);
                check_output($sformatf("add_pattern%0d", i), {24'd0, pat_r[i]},
                             {24'd0, e.pat});
            end
        end
        prev_done[i] = done_o[i];
    endtask

    always @(negedge clk) begin
        if (n_reset) begin
            for (int i = 0; i < 2; i++) monitor_step(i);
        end
    end

    // Issue one start. When push is set, the expected result is queued for
    // the monitor. The start edge is recorded so latency can count the LOAD
    // cycle as cycle 1.
    task automatic apply_stimulus(input int i, input logic [7:0] mc,
                                  input logic [7:0] mp, input bit push,
                                  input int prod, input int lat);
        exp_t e;
        @(negedge clk);
        mcand[i]   = mc;
        mplier[i]  = mp;
        start_s[i] = 1'b1;
        @(posedge clk);
        #1;
        start_s[i] = 1'b0;
        if (push) begin
            e.product    = prod[15:0];
            e.lat        = lat;
            e.pat        = mp;
            e.start_edge = edge_cnt;
            if (i == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
        check_output("load_reset", {31'd0, rst_o[i]}, 32'd1);
    endtask

    task automatic wait_done(input int i);
        int n;
        n = 0;
        while (!done_o[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done_o[i]) check_output("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic acknowledge(input int i);
        @(negedge clk);
        ack_s[i] = 1'b1;
        @(posedge clk);
        #1;
        ack_s[i] = 1'b0;
        check_output("ready_after_ack", {31'd0, ready_o[i]}, 32'd1);
    endtask

    task automatic run_full(input int i, input logic [7:0] mc, input logic [7:0] mp,
                            input int prod, input int lat);
        apply_stimulus(i, mc, mp, 1'b1, prod, lat);
        wait_done(i);
        acknowledge(i);
    endtask

    task automatic check_idle(input int i, input string tag, input int cnt);
        check_output({tag, "_ready"}, {31'd0, ready_o[i]}, 32'd1);
        check_output({tag, "_busy"},  {31'd0, busy_o[i]},  32'd0);
        check_output({tag, "_done"},  {31'd0, done_o[i]},  32'd0);
        check_output({tag, "_ctrl"},
                     {29'd0, rst_o[i], add_o[i], shift_o[i]}, 32'd0);
        check_output({tag, "_count"}, {28'd0, count_o[i]}, cnt);
    endtask

    initial begin
        int n;
        errors   = 0;
        checks   = 0;
        edge_cnt = 0;
        n_reset  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i]   = 1'b0;
            abort_s[i]   = 1'b0;
            ack_s[i]     = 1'b0;
            dp[i]        = '0;
            mcand[i]     = '0;
            mplier[i]    = '0;
            shifts[i]    = 0;
            pat_r[i]     = '0;
            prev_add[i]  = 1'b0;
            prev_done[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_idle(0, "reset0", 0);
        check_idle(1, "reset1", 0);
        n_reset = 1'b1;

        // Directed products; latency is WIDTH+2 (+popcount in separate mode)
        run_full(0, 8'd13,  8'h0B, 143,   10);
        run_full(0, 8'd99,  8'h00, 0,     10);
        run_full(1, 8'hFF,  8'hFF, 65025, 18);
        run_full(1, 8'h37,  8'h00, 0,     10);
        run_full(1, 8'd13,  8'h0B, 143,   13);

        // Abort at count=3 while running, then a clean 7 x 5
        apply_stimulus(0, 8'd9, 8'h0B, 1'b0, 0, 0);
        n = 0;
        while (!(busy_o[0] && shift_o[0] && count_o[0] == 4'd3) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("abort_reached_count3", {28'd0, count_o[0]}, 32'd3);
        abort_s[0] = 1'b1;
        @(posedge clk);
        #1;
        abort_s[0] = 1'b0;
        check_idle(0, "abort", 3);
        run_full(0, 8'd7, 8'd5, 35, 10);

        // DONE held without ack while start toggles, then back-to-back start
        apply_stimulus(1, 8'd6, 8'd9, 1'b1, 54, 12);
        wait_done(1);
        for (int k = 0; k < 5; k++) begin
            start_s[1] = k[0];
            @(negedge clk);
            check_output("done_held", {31'd0, done_o[1]}, 32'd1);
            check_output("no_reload", {31'd0, rst_o[1]}, 32'd0);
        end
        mcand[1]   = 8'd12;
        mplier[1]  = 8'h80;
        start_s[1] = 1'b1;
        ack_s[1]   = 1'b1;
        @(posedge clk);
        #1;
        start_s[1] = 1'b0;
        ack_s[1]   = 1'b0;
        begin
            exp_t e;
            e.product    = 16'd1536;
            e.lat        = 11;
            e.pat        = 8'h80;
            e.start_edge = edge_cnt;
            sb1.push_back(e);
        end
        check_output("b2b_reset_on", {31'd0, rst_o[1]}, 32'd1);
        @(posedge clk);
        #1;
        check_output("b2b_reset_off", {31'd0, rst_o[1]}, 32'd0);
        wait_done(1);
        acknowledge(1);

        // Asynchronous reset between edges in the middle of RUN
        apply_stimulus(0, 8'hAA, 8'd3, 1'b0, 0, 0);
        n = 0;
        while (!(busy_o[0] && count_o[0] == 4'd2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        #2;
        n_reset = 1'b0;
        #1;
        check_idle(0, "async_reset", 0);
        @(negedge clk);
        n_reset = 1'b1;

        repeat (5) @(negedge clk);
        check_output("scoreboard_drained", sb0.size() + sb1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
